// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types for the instruction fetch front end
// Contents: word_t, the HALT opcode, the fetch state enum and the buffer entry struct.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    localparam logic [5:0] HALT_OP = 6'h3F;
    typedef enum logic [1:0] {IDLE, FETCH, HALTED} fetch_state_t;
    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: PC register, instruction memory and decode signals of the fetch unit
// master = fetch unit side; slave = environment (PC register, imem, redirect source, decode).
interface ifetch_unit_if;
    import cpu_types_pkg::*;
    word_t pco, pc_next, iaddr, iload, redirect_addr, inst, inst_pc, inst_npc;
    logic  pc_wen, iREN, ihit, redirect, inst_ready, inst_valid, halted;
    modport master (
        input  pco, ihit, iload, redirect, redirect_addr, inst_ready,
        output pc_wen, pc_next, iREN, iaddr, inst_valid, inst, inst_pc, inst_npc, halted
    );
    modport slave (
        output pco, ihit, iload, redirect, redirect_addr, inst_ready,
        input  pc_wen, pc_next, iREN, iaddr, inst_valid, inst, inst_pc, inst_npc, halted
    );
endinterface

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: circular buffer of fetched {instr, pc} entries with push/pop/flush
// Ports: CLK, nRST (async active-low), push/din, pop, flush, head (oldest entry), count (0..DEPTH).
// Flush wins over push and pop in the same cycle.
module ifetch_buffer
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd, wr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd];

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= inc(wr);
            end
            if (pop) rd <= inc(rd);
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch front end driving the PC register and feeding decode through a buffer
// Ports: CLK, nRST (async active-low), fif (ifetch_unit_if.master): pco/pc_wen/pc_next to the
// PC register, iREN/iaddr/ihit/iload to instruction memory, redirect/redirect_addr from execute,
// inst_valid/inst_ready/inst/inst_pc/inst_npc to decode, halted status.
// Build option IFETCH_QUEUE_EN: DEPTH-entry buffer; otherwise a single holding register.
module ifetch_unit
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic           CLK,
    input logic           nRST,
    ifetch_unit_if.master fif
);
`ifdef IFETCH_QUEUE_EN
    localparam int D = DEPTH;
`else
    localparam int D = (DEPTH > 1) ? 1 : DEPTH;
`endif
    localparam int CW = $clog2(D + 1);

    fetch_state_t  state, next_state;
    fetch_entry_t  head, din;
    logic [CW-1:0] count;
    logic          pop, accept, is_halt;

    assign fif.inst_valid = count != '0;
    assign pop            = fif.inst_valid & fif.inst_ready;
    assign fif.iaddr      = fif.pco;
    // a full buffer may still take a fetch when its head leaves this cycle
    assign fif.iREN       = state == FETCH && !fif.redirect && (count != CW'(D) || pop);
    assign accept         = fif.iREN & fif.ihit;
    assign is_halt        = fif.iload[31:26] == HALT_OP;
    assign fif.pc_wen     = fif.redirect | (accept & !is_halt);
    assign fif.pc_next    = fif.redirect ? fif.redirect_addr : fif.pco + 32'd4;
    assign fif.halted     = state == HALTED;
    assign fif.inst       = head.instr;
    assign fif.inst_pc    = head.pc;
    assign fif.inst_npc   = head.pc + 32'd4;
    assign din            = {fif.iload, fif.pco};

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= IDLE;
        else       state <= next_state;

    always_comb begin
        next_state = state;
        next_state = (state == IDLE || fif.redirect) ? FETCH :
                     (accept && is_halt)             ? HALTED : state;
    end

    ifetch_buffer #(.DEPTH(D)) u_buf (
        .CLK  (CLK),
        .nRST (nRST),
        .push (accept),
        .pop  (pop & !fif.redirect),
        .flush(fif.redirect),
        .din  (din),
        .head (head),
        .count(count)
    );
endmodule
